// File: rtl/mul4_fitness_evaluator.sv
// Drives pseudo-random operands into a mul4 candidate and scores its outputs against a serial golden product.
// Optional MUL4_FAIL_CAPTURE_EN adds first-failure capture ports.
module mul4_fitness_evaluator #(
  parameter int unsigned NUM_VECTORS   = 64,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [63:0] SEED          = 64'hACE1_2468_1357_BEEF,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [15:0]      dut_a1,
  output logic [15:0]      dut_a0,
  output logic [15:0]      dut_b1,
  output logic [15:0]      dut_b0,
  input  logic [15:0]      dut_y3,
  input  logic [15:0]      dut_y2,
  input  logic [15:0]      dut_y1,
  input  logic [15:0]      dut_y0,
`ifdef MUL4_FAIL_CAPTURE_EN
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [63:0]      first_fail_ops,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] bit_err_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_MULT   = 3'd3;
  localparam logic [2:0] ST_CMP    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [63:0] SEED_EFF  = (SEED == 64'd0) ? 64'd1 : SEED;
  // Right-shifting Galois form of x^64+x^63+x^61+x^60+1
  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

  logic [2:0]       state_q;
  logic [63:0]      lfsr_q, ops_q, cap_q, prod_q, mcand_q;
  logic [31:0]      mplier_q, cyc_q;
  logic [CNT_W-1:0] vec_q, pass_q, err_q;

  logic             start_ok, last_vec, diff_zero;
  logic [63:0]      lfsr_adv, diff;
  logic [6:0]       diff_ones;
  logic [CNT_W-1:0] vec_d, pass_d, err_d;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [6:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    lfsr_adv  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 64'd0);
    diff      = cap_q ^ prod_q;
    diff_zero = (diff == 64'd0);
    diff_ones = popcount64(diff);
    vec_d     = sat_add(vec_q, 7'd1);
    pass_d    = sat_add(pass_q, diff_zero ? 7'd1 : 7'd0);
    err_d     = sat_add(err_q, diff_ones);
    // A saturated vector count also ends the run so it can never stall
    last_vec  = (vec_q == '1) || ((32'(vec_q) + 32'd1) >= NUM_VECTORS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= SEED_EFF;
      ops_q    <= '0;
      cap_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cyc_q    <= '0;
      vec_q    <= '0;
      pass_q   <= '0;
      err_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            vec_q   <= '0;
            pass_q  <= '0;
            err_q   <= '0;
            lfsr_q  <= SEED_EFF;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          ops_q    <= lfsr_q;
          mcand_q  <= {32'd0, lfsr_q[63:32]};
          mplier_q <= lfsr_q[31:0];
          prod_q   <= '0;
          lfsr_q   <= lfsr_adv;
          cyc_q    <= '0;
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cyc_q == SETTLE_CYCLES - 1) begin
            cap_q   <= {dut_y3, dut_y2, dut_y1, dut_y0};
            cyc_q   <= '0;
            state_q <= ST_MULT;
          end else begin
            cyc_q <= cyc_q + 32'd1;
          end
        end
        ST_MULT: begin
          prod_q   <= prod_q + (mplier_q[0] ? mcand_q : 64'd0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cyc_q == 32'd31) state_q <= ST_CMP;
          else cyc_q <= cyc_q + 32'd1;
        end
        ST_CMP: begin
          vec_q   <= vec_d;
          pass_q  <= pass_d;
          err_q   <= err_d;
          state_q <= last_vec ? ST_DONE : ST_LOAD;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MUL4_FAIL_CAPTURE_EN
  logic             ff_valid_q;
  logic [CNT_W-1:0] ff_idx_q;
  logic [63:0]      ff_ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      ff_ops_q   <= '0;
    end else if (start_ok) begin
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      ff_ops_q   <= '0;
    end else if ((state_q == ST_CMP) && !diff_zero && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_idx_q   <= vec_q;
      ff_ops_q   <= ops_q;
    end
  end

  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_ops   = ff_ops_q;
`endif

  assign {dut_a1, dut_a0, dut_b1, dut_b0} = ops_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign vec_count     = vec_q;
  assign pass_count    = pass_q;
  assign bit_err_count = err_q;

endmodule

// File: tb/tb_mul4_fitness_evaluator.sv
// Directed bench for mul4_fitness_evaluator: one 8-vector instance with a modal candidate model,
// and a SEED=0 single-vector instance.
module tb_mul4_fitness_evaluator;

  localparam int unsigned CW = 16;
  localparam logic [63:0] SEED = 64'hACE1_2468_1357_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, rst0_n, start0;
  logic [15:0]   a1, a0, b1, b0, y3, y2, y1, y0;
  logic          busy, done;
  logic [CW-1:0] vec, pass, err;
  logic [15:0]   p0_a1, p0_a0, p0_b1, p0_b0;
  logic          p0_busy, p0_done;
  logic [CW-1:0] p0_vec, p0_pass, p0_err;
`ifdef MUL4_FAIL_CAPTURE_EN
  logic          ff_valid, p0_ff_valid;
  logic [CW-1:0] ff_idx, p0_ff_idx;
  logic [63:0]   ff_ops, p0_ff_ops;
`endif

  int          mode;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] gold, y_all, exp_last;
  int          exp_zero_err;

  // Candidate model: 0 exact, 1 all-zero, 2 exact with bit 0 inverted
  always_comb begin
    gold  = 64'({a1, a0}) * 64'({b1, b0});
    y_all = gold;
    if (mode == 1) y_all = 64'd0;
    else if (mode == 2) y_all = gold ^ 64'd1;
  end
  assign {y3, y2, y1, y0} = y_all;

  mul4_fitness_evaluator #(
    .NUM_VECTORS(8), .SETTLE_CYCLES(2), .SEED(SEED), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a1(a1), .dut_a0(a0), .dut_b1(b1), .dut_b0(b0),
    .dut_y3(y3), .dut_y2(y2), .dut_y1(y1), .dut_y0(y0),
`ifdef MUL4_FAIL_CAPTURE_EN
    .first_fail_valid(ff_valid), .first_fail_idx(ff_idx), .first_fail_ops(ff_ops),
`endif
    .busy(busy), .done(done), .vec_count(vec), .pass_count(pass), .bit_err_count(err)
  );

  mul4_fitness_evaluator #(
    .NUM_VECTORS(1), .SETTLE_CYCLES(2), .SEED(64'd0), .CNT_W(CW)
  ) dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0),
    .dut_a1(p0_a1), .dut_a0(p0_a0), .dut_b1(p0_b1), .dut_b0(p0_b0),
    .dut_y3(16'd0), .dut_y2(16'd0), .dut_y1(16'd0), .dut_y0(16'd0),
`ifdef MUL4_FAIL_CAPTURE_EN
    .first_fail_valid(p0_ff_valid), .first_fail_idx(p0_ff_idx), .first_fail_ops(p0_ff_ops),
`endif
    .busy(p0_busy), .done(p0_done), .vec_count(p0_vec), .pass_count(p0_pass),
    .bit_err_count(p0_err)
  );

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    logic [63:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 64'hD800_0000_0000_0000;
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_vec(input int target);
    int n;
    n = 0;
    while (vec != CW'(target) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst0_n = 1'b0; start = 1'b0; start0 = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a1, a0, b1, b0} !== 64'd0) begin
      errors++; $display("FAIL reset_ops: got %h want 0", {a1, a0, b1, b0});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if ({vec, pass, err} !== '0) begin
      errors++; $display("FAIL reset_counts: got %0d %0d %0d want 0 0 0", vec, pass, err);
    end
    @(negedge clk);
    rst_n = 1'b1; rst0_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || vec !== '0 || {a1, a0, b1, b0} !== 64'd0) begin
      errors++; $display("FAIL idle_quiet: got busy=%b vec=%0d want 0 0", busy, vec);
    end
  endtask

  task automatic test_exact();
    int n;
    mode = 0;
    pulse_start();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL exact_busy: got busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(400, n);
    checks++;
    if (n != 288 || done !== 1'b1) begin
      errors++; $display("FAIL exact_latency: got %0d edges done=%b want 288 1", n, done);
    end
    checks++;
    if (vec !== CW'(8) || pass !== CW'(8) || err !== CW'(0)) begin
      errors++; $display("FAIL exact_counts: got %0d %0d %0d want 8 8 0", vec, pass, err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL exact_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_zero();
    int n;
    mode = 1;
    pulse_start();
    wait_done(400, n);
    checks++;
    if (vec !== CW'(8) || pass !== CW'(0) || err !== CW'(exp_zero_err)) begin
      errors++;
      $display("FAIL zero_counts: got %0d %0d %0d want 8 0 %0d", vec, pass, err, exp_zero_err);
    end
    checks++;
    if ({a1, a0, b1, b0} !== exp_last) begin
      errors++; $display("FAIL zero_last_ops: got %h want %h", {a1, a0, b1, b0}, exp_last);
    end
  endtask

  task automatic test_flip();
    int n;
    mode = 2;
    pulse_start();
    wait_done(400, n);
    checks++;
    if (vec !== CW'(8) || pass !== CW'(0) || err !== CW'(8)) begin
      errors++; $display("FAIL flip_counts: got %0d %0d %0d want 8 0 8", vec, pass, err);
    end
`ifdef MUL4_FAIL_CAPTURE_EN
    checks++;
    if (ff_valid !== 1'b1 || ff_idx !== CW'(0) || ff_ops !== SEED) begin
      errors++;
      $display("FAIL flip_capture: got %b %0d %h want 1 0 %h", ff_valid, ff_idx, ff_ops, SEED);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int n;
    mode = 1;
    pulse_start();
    wait_vec(3);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || vec !== CW'(3)) begin
      errors++; $display("FAIL busy_start: got busy=%b vec=%0d want 1 3", busy, vec);
    end
    wait_done(400, n);
    checks++;
    if (vec !== CW'(8) || pass !== CW'(0) || err !== CW'(exp_zero_err)) begin
      errors++;
      $display("FAIL busy_start_counts: got %0d %0d %0d want 8 0 %0d", vec, pass, err, exp_zero_err);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 1;
    pulse_start();
    wait_vec(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || {vec, pass, err} !== '0 || {a1, a0, b1, b0} !== 64'd0) begin
      errors++;
      $display("FAIL midreset: got busy=%b done=%b vec=%0d ops=%h want all 0",
               busy, done, vec, {a1, a0, b1, b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || vec !== '0) begin
      errors++; $display("FAIL midreset_idle: got busy=%b vec=%0d want 0 0", busy, vec);
    end
    pulse_start();
    wait_done(400, n);
    checks++;
    if (n != 288 || vec !== CW'(8) || pass !== CW'(0) || err !== CW'(exp_zero_err)) begin
      errors++;
      $display("FAIL midreset_rerun: got n=%0d %0d %0d %0d want 288 8 0 %0d",
               n, vec, pass, err, exp_zero_err);
    end
  endtask

  task automatic test_seed0();
    for (int r = 0; r < 2; r++) begin
      int n;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      checks++;
      if (p0_busy !== 1'b1 || p0_done !== 1'b0 || p0_vec !== '0) begin
        errors++;
        $display("FAIL seed0_start%0d: got busy=%b done=%b vec=%0d want 1 0 0",
                 r, p0_busy, p0_done, p0_vec);
      end
      n = 0;
      while (!p0_done && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++;
      if (n != 36 || {p0_a1, p0_a0, p0_b1, p0_b0} !== 64'd1) begin
        errors++;
        $display("FAIL seed0_ops%0d: got n=%0d ops=%h want 36 1", r, n, {p0_a1, p0_a0, p0_b1, p0_b0});
      end
      checks++;
      if (p0_vec !== CW'(1) || p0_pass !== CW'(1) || p0_err !== CW'(0)) begin
        errors++;
        $display("FAIL seed0_counts%0d: got %0d %0d %0d want 1 1 0", r, p0_vec, p0_pass, p0_err);
      end
    end
  endtask

  initial begin
    logic [63:0] v;
    v = SEED;
    exp_zero_err = 0;
    for (int i = 0; i < 8; i++) begin
      exp_zero_err += $countones(64'(v[63:32]) * 64'(v[31:0]));
      exp_last = v;
      v = lfsr_step(v);
    end
    test_reset();
    test_exact();
    test_zero();
    test_flip();
    test_start_ignored();
    test_reset_mid();
    test_seed0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
